// File: rtl/bool_unit_arbiter.sv
// Four-requester round-robin arbiter feeding a registered bitwise boolean unit.
// Define BOOL_ARB_PARITY_EN to add the registered res_par output.
module bool_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] op_a,
    input  logic [4*WIDTH-1:0] op_b,
    input  logic [11:0]        opc,
    output logic [3:0]         gnt,
    output logic               res_valid,
    output logic [WIDTH-1:0]   res_data,
    output logic [1:0]         res_id,
    input  logic               res_ready
`ifdef BOOL_ARB_PARITY_EN
    ,
    output logic               res_par
`endif
);

    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         ptr;
    logic [1:0]         winner;
    logic [1:0]         idx;
    logic               found;
    logic               accept;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [2:0]         c_sel;
    logic [WIDTH-1:0]   result;

    function automatic logic [WIDTH-1:0] bool_op(
        input logic [2:0]       c,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        unique case (c)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a & b);
            3'b100:  r = ~(a | b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // Search starts at ptr and wraps; first set request wins.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // rst_n gating keeps gnt low while reset is held, even with req set.
    assign accept = rst_n && (req != 4'b0000)
                 && ((state == IDLE) || res_ready);

    assign a_sel  = op_a[winner*WIDTH +: WIDTH];
    assign b_sel  = op_b[winner*WIDTH +: WIDTH];
    assign c_sel  = opc[winner*3 +: 3];
    assign result = bool_op(c_sel, a_sel, b_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = FULL;
            FULL: if (accept) state_nxt = FULL;
                  else if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        res_valid = (state == FULL);
        gnt       = 4'b0000;
        if (accept) gnt = 4'b0001 << winner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 2'd0;
            res_data <= '0;
            res_id   <= 2'd0;
        end else if (accept) begin
            ptr      <= winner + 2'd1;
            res_data <= result;
            res_id   <= winner;
        end
    end

`ifdef BOOL_ARB_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_par <= 1'b0;
        end else if (accept) begin
            res_par <= ^result;
        end
    end
`endif

endmodule

// File: tb/tb_bool_unit_arbiter.sv
// Directed bench for bool_unit_arbiter (WIDTH=8).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_bool_unit_arbiter;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] op_a;
    logic [4*W-1:0] op_b;
    logic [11:0]    opc;
    logic [3:0]     gnt;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic [1:0]     res_id;
    logic           res_ready;
`ifdef BOOL_ARB_PARITY_EN
    logic           res_par;
`endif

    int total;
    int bad;

    bool_unit_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .opc       (opc),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
`ifdef BOOL_ARB_PARITY_EN
        ,
        .res_par   (res_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] sweep_exp [8];
    logic [3:0] rr_gnt [5];
    logic [7:0] rr_data [4];

    initial begin
        total = 0;
        bad   = 0;
        sweep_exp = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};
        rr_gnt    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_data   = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst_n = 1'b0; req = 4'b0000; op_a = '0; op_b = '0; opc = '0;
        res_ready = 1'b0;

        // reset state, including gnt staying low with requests present
        #2;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        req = 4'b1111;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // single XOR op from requester 0
        @(negedge clk);
        req = 4'b0001; op_a[7:0] = 8'hF0; op_b[7:0] = 8'h3C; opc[2:0] = 3'b010;
        #1;
        chk("single_gnt", 32'(gnt), 32'b0001);
        @(negedge clk);
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_data", 32'(res_data), 32'hCC);
        chk("single_id", 32'(res_id), 32'd0);
        req = 4'b0000; res_ready = 1'b1;
        #1;
        chk("drain_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("idle_valid", 32'(res_valid), 32'd0);

        // opcode sweep on requester 1, one result per cycle
        op_a[15:8] = 8'hA5; op_b[15:8] = 8'h0F; req = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk("sweep_data", 32'(res_data), 32'(sweep_exp[k-1]));
            end
            opc[5:3] = 3'(k);
            #1;
            chk("sweep_gnt", 32'(gnt), 32'b0010);
        end
        @(negedge clk);
        chk("sweep_last", 32'(res_data), 32'(sweep_exp[7]));
        chk("sweep_id", 32'(res_id), 32'd1);
        req = 4'b0000;

        // round-robin from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        op_a = {8'h44, 8'h33, 8'h22, 8'h11};
        opc  = {3'b111, 3'b111, 3'b111, 3'b111};
        req  = 4'b1111; res_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin
                @(negedge clk);
                chk("rr_id", 32'(res_id), 32'(s - 1));
                chk("rr_data", 32'(res_data), 32'(rr_data[s-1]));
            end
            #1;
            chk("rr_gnt", 32'(gnt), 32'(rr_gnt[s]));
        end

        // backpressure with requester 2 waiting
        @(negedge clk);
        chk("bp_id0", 32'(res_id), 32'd0);
        chk("bp_data0", 32'(res_data), 32'h11);
        req = 4'b0100; res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_gnt", 32'(gnt), 32'd0);
            chk("bp_data", 32'(res_data), 32'h11);
            chk("bp_valid", 32'(res_valid), 32'd1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(gnt), 32'b0100);
        @(negedge clk);
        chk("bp_new_data", 32'(res_data), 32'h33);
        chk("bp_new_id", 32'(res_id), 32'd2);

        // asynchronous reset while holding a result
        req = 4'b0000; res_ready = 1'b0;
        #2;
        chk("mid_valid_pre", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(res_valid), 32'd0);
        chk("mid_data", 32'(res_data), 32'd0);
        req = 4'b1010;
        #1;
        chk("mid_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b0010);
        @(negedge clk);
        chk("post_rst_id", 32'(res_id), 32'd1);
        chk("post_rst_data", 32'(res_data), 32'h22);

        // PASS a=07 from requester 3 (ptr now 2, req 1000 only)
        req = 4'b1000; res_ready = 1'b1;
        op_a[31:24] = 8'h07; opc[11:9] = 3'b111;
        #1;
        chk("par_gnt", 32'(gnt), 32'b1000);
        @(negedge clk);
        chk("par_data", 32'(res_data), 32'h07);
`ifdef BOOL_ARB_PARITY_EN
        chk("par_bit", 32'(res_par), 32'd1);
`endif
        req = 4'b0000;
        @(negedge clk);
        chk("final_idle", 32'(res_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bool_unit_arbiter.md
BOOL_UNIT_ARBITER -- requirements
Module: bool_unit_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  per-requester request; bit i belongs to requester i.
- op_a  in  4*WIDTH  operand A; slice i belongs to requester i.
- op_b  in  4*WIDTH  operand B; slice i belongs to requester i.
- opc  in  4*3  opcode; slice i belongs to requester i.
- gnt  out  4  one-hot accept strobe, combinational, high in the accept cycle.
- res_valid  out  1  result available.
- res_data  out  WIDTH  registered result.
- res_id  out  2  index of the requester that owns res_data.
- res_ready  in  1  consumer accepts the result.

Function
REQ-004 Opcode encoding SHALL be: 000 AND; 001 OR; 010 XOR; 011 NAND; 100 NOR; 101 XNOR; 110 NOT a; 111 PASS a.
REQ-005 All operations SHALL be bitwise over WIDTH bits, and op_b SHALL be ignored for opcodes 110 and 111.
REQ-006 The FSM SHALL have two states:
- IDLE: no result held.
- FULL: result held, res_valid=1.
REQ-007 An accept SHALL occur in a cycle when (state==IDLE or res_ready==1) and req!=0.
REQ-008 In an accept cycle, exactly one gnt bit SHALL be high, and it SHALL be the winning requester's bit.
REQ-009 gnt SHALL be 0 in every cycle without an accept.
REQ-010 Arbitration SHALL be round-robin with pointer ptr (2 bits): search starts at ptr, then ptr+1 mod 4, and so on; the first set req bit wins.
REQ-011 On every accept, ptr SHALL be loaded with winner+1 mod 4 (3 wraps to 0).
REQ-012 ptr SHALL be unchanged in cycles without an accept.
REQ-013 On the clock edge ending an accept cycle, the block SHALL:
- register the winner's result into res_data;
- register the winner index into res_id;
- move to state FULL.
REQ-014 Latency SHALL be 1 cycle: res_valid is high in the cycle after gnt.
REQ-015 In FULL with res_ready=0, the block SHALL:
- hold res_data, res_id and res_valid stable;
- keep gnt=0.
REQ-016 In FULL with res_ready=1 and req==0, the block SHALL return to IDLE on the next edge.
REQ-017 In FULL with res_ready=1 and req!=0, the result SHALL be consumed and a new one accepted in the same cycle, with the state remaining FULL.
REQ-018 Back-to-back operation SHALL sustain one operation per cycle.
REQ-019 In IDLE, res_ready SHALL be ignored.
REQ-020 Requesters SHALL hold req, operands and opcode stable until their gnt, and the block SHALL sample them only in the accept cycle.
REQ-021 A requester deasserting req before its grant SHALL simply lose arbitration, with no error state.

Reset
REQ-022 While rst_n=0, the block SHALL immediately force:
- state=IDLE, res_valid=0, res_data=0, res_id=0, ptr=0, gnt=0.
REQ-023 Assertion of rst_n SHALL discard any held result, without requiring a clock edge.
REQ-024 The first accept after reset release SHALL favour requester 0.

Configuration
REQ-025 With macro BOOL_ARB_PARITY_EN defined, the block SHALL add output res_par (1 bit) = XOR-reduction of res_data.
REQ-026 res_par SHALL be registered alongside res_data, with a reset value of 0.
REQ-027 Without BOOL_ARB_PARITY_EN, the res_par port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-028 Single op: the bench SHALL drive req=0001, a0=8'hF0, b0=8'h3C, opc0=010 -> gnt=0001 that cycle; next cycle res_valid=1, res_data=8'hCC, res_id=0.
REQ-029 Opcode sweep: the bench SHALL drive a=8'hA5, b=8'h0F, opcodes 000..111 with res_ready=1 -> results 05, AF, AA, FA, 50, 55, 5A, A5 on consecutive cycles.
REQ-030 Round-robin: the bench SHALL hold req=1111 continuously with res_ready=1 after reset -> gnt sequence 0001, 0010, 0100, 1000, 0001; res_id follows 0, 1, 2, 3, 0.
REQ-031 Backpressure: the bench SHALL hold res_ready=0 for 3 cycles while FULL with req=0100 -> gnt=0 and res_data stable for those 3 cycles; on res_ready=1, gnt=0100 in that cycle.
REQ-032 Reset mid-operation: the bench SHALL assert rst_n=0 asynchronously while FULL -> res_valid=0 immediately; after release with req=1010, the first gnt=0010.
REQ-033 Parity (macro defined): the bench SHALL drive a=8'h07, opc=111 -> res_data=8'h07, res_par=1.
